// File: rtl/occupancy_map_streamer.sv
// Streams occupancy-grid cells (full map or window) in row-major order over valid/ready.
// Reads are issued to a 1-cycle-latency RAM; a 2-entry skid buffer absorbs backpressure.
module occupancy_map_streamer #(
    parameter int MAP_WIDTH  = 256,
    parameter int MAP_HEIGHT = 128,
    parameter int CELL_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(MAP_WIDTH*MAP_HEIGHT),
    parameter int X_WIDTH    = $clog2(MAP_WIDTH),
    parameter int Y_WIDTH    = $clog2(MAP_HEIGHT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  full_map,
    input  logic [X_WIDTH-1:0]    win_x0,
    input  logic [X_WIDTH-1:0]    win_x1,
    input  logic [Y_WIDTH-1:0]    win_y0,
    input  logic [Y_WIDTH-1:0]    win_y1,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [CELL_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CELL_WIDTH-1:0] out_data,
    output logic [X_WIDTH-1:0]    out_x,
    output logic [Y_WIDTH-1:0]    out_y,
    output logic                  out_last
);

    typedef struct packed {
        logic [CELL_WIDTH-1:0] data;
        logic [X_WIDTH-1:0]    x;
        logic [Y_WIDTH-1:0]    y;
        logic                  last;
    } beat_t;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

    state_t                r_state;
    logic [X_WIDTH-1:0]    r_x0, r_x1, r_cx;
    logic [Y_WIDTH-1:0]    r_y1, r_cy;
    logic                  r_busy, r_done, r_error;
    logic                  r_rd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [X_WIDTH-1:0]    r_rd_x, r_ret_x;
    logic [Y_WIDTH-1:0]    r_rd_y, r_ret_y;
    logic                  r_rd_last, r_ret_last, r_ret;
    beat_t                 r_buf [2];
    logic [1:0]            r_cnt;

    logic [X_WIDTH-1:0]    w_bx0, w_bx1, w_ix, w_lx0, w_lx1;
    logic [Y_WIDTH-1:0]    w_by0, w_by1, w_iy, w_ly1;
    logic                  w_bad, w_issue, w_ilast, w_head_v, w_pop;
    logic [ADDR_WIDTH-1:0] w_iaddr;
    logic [1:0]            w_cnt_n, w_wr_pos;
    beat_t                 w_ret_beat, w_head;
    beat_t                 w_buf_n [2];

    always_comb begin
        w_bx0 = full_map ? '0 : win_x0;
        w_bx1 = full_map ? X_WIDTH'(MAP_WIDTH-1) : win_x1;
        w_by0 = full_map ? '0 : win_y0;
        w_by1 = full_map ? Y_WIDTH'(MAP_HEIGHT-1) : win_y1;
        w_bad = !full_map && ((win_x0 > win_x1) || (win_y0 > win_y1) ||
                              (int'(win_x1) >= MAP_WIDTH) || (int'(win_y1) >= MAP_HEIGHT));
    end

    // The RAM return acts as the head entry while the buffer is empty, so a
    // beat can be offered in the same cycle its data comes back.
    always_comb begin
        w_ret_beat = {mem_rd_data, r_ret_x, r_ret_y, r_ret_last};
        w_head     = (r_cnt != 2'd0) ? r_buf[0] : w_ret_beat;
        w_head_v   = (r_cnt != 2'd0) || r_ret;
        w_pop      = w_head_v && out_ready;
        w_cnt_n    = r_cnt + {1'b0, r_ret} - {1'b0, w_pop};
        w_wr_pos   = (r_cnt != 2'd0) ? (r_cnt - {1'b0, w_pop}) : 2'd0;
        w_buf_n    = r_buf;
        if (w_pop && (r_cnt != 2'd0))
            w_buf_n[0] = r_buf[1];
        if (r_ret && !(w_pop && (r_cnt == 2'd0)))
            w_buf_n[w_wr_pos[0]] = w_ret_beat;
    end

    always_comb begin
        w_ix    = (r_state == IDLE) ? w_bx0 : r_cx;
        w_iy    = (r_state == IDLE) ? w_by0 : r_cy;
        w_lx0   = (r_state == IDLE) ? w_bx0 : r_x0;
        w_lx1   = (r_state == IDLE) ? w_bx1 : r_x1;
        w_ly1   = (r_state == IDLE) ? w_by1 : r_y1;
        w_ilast = (w_ix == w_lx1) && (w_iy == w_ly1);
        w_iaddr = ADDR_WIDTH'(w_iy) * ADDR_WIDTH'(MAP_WIDTH) + ADDR_WIDTH'(w_ix);
        // Next-cycle occupancy: the read now in flight plus what stays buffered.
        w_issue = ((r_state == IDLE) && start && !w_bad) ||
                  ((r_state == SCAN) && (({2'b0, r_rd} + {1'b0, w_cnt_n}) < 3'd2));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_x0       <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_rd       <= 1'b0;
            r_addr     <= '0;
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_rd_last  <= 1'b0;
            r_ret      <= 1'b0;
            r_ret_x    <= '0;
            r_ret_y    <= '0;
            r_ret_last <= 1'b0;
            r_buf      <= '{default: '0};
            r_cnt      <= '0;
        end else begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_buf      <= w_buf_n;
            r_cnt      <= w_cnt_n;
            r_ret      <= r_rd;
            r_ret_x    <= r_rd_x;
            r_ret_y    <= r_rd_y;
            r_ret_last <= r_rd_last;
            r_rd       <= w_issue;
            if (w_issue) begin
                r_addr    <= w_iaddr;
                r_rd_x    <= w_ix;
                r_rd_y    <= w_iy;
                r_rd_last <= w_ilast;
                r_cx      <= (w_ix == w_lx1) ? w_lx0 : w_ix + 1'b1;
                r_cy      <= (w_ix == w_lx1) ? w_iy + 1'b1 : w_iy;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_bad) begin
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                        end else begin
                            r_x0    <= w_bx0;
                            r_x1    <= w_bx1;
                            r_y1    <= w_by1;
                            r_busy  <= 1'b1;
                            r_state <= w_ilast ? DRAIN : SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (w_issue && w_ilast)
                        r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!r_rd && (w_cnt_n == 2'd0)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end
                end
                FINISH:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign mem_rd_en = r_rd;
    assign mem_addr  = r_addr;
    assign out_valid = w_head_v;
    assign out_data  = w_head_v ? w_head.data : '0;
    assign out_x     = w_head_v ? w_head.x : '0;
    assign out_y     = w_head_v ? w_head.y : '0;
    assign out_last  = w_head_v && w_head.last;

endmodule
